// File: rtl/gpio_port.sv
// gpio_port: WIDTH-pin GPIO slave for the PicoRV32-style native memory bus.
//
// Word registers at mem_addr[4:2]:
//   0 OUT  (rw)  1 DIR (rw)  2 IN (ro)  3 SET (wo)  4 CLR (wo)  5 TGL (wo)
//   6 IEN  (rw)  7 ISTAT (rw1c)
// Writes honour the byte strobes. Every access is acknowledged with a one-cycle
// mem_ready pulse, and mem_rdata carries the value the register held before
// that access.
//
// Optional feature macro: GPIO_IRQ_EN. When it is defined, the bus gets the
// IEN/ISTAT registers and a rising-edge interrupt on irq. When it is not
// defined, indices 6 and 7 read 0 and irq is tied low.
//
// Ports:
//   clk, resetn           system clock, asynchronous active-low reset
//   mem_valid, CS         request valid, chip select from the address decoder
//   mem_addr, mem_wdata   byte address (only [4:2] is used), write data
//   mem_wstrb             byte write strobes (0 = read)
//   mem_ready, mem_rdata  acknowledge pulse, registered read data
//   gpio_i                asynchronous pin inputs
//   gpio_o, gpio_oe       output data, output enable (1 = drive the pin)
//   irq                   registered level interrupt
module gpio_port #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_rdata,
    input  logic             CS,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] IDX_OUT   = 3'd0;
    localparam logic [2:0] IDX_DIR   = 3'd1;
    localparam logic [2:0] IDX_IN    = 3'd2;
    localparam logic [2:0] IDX_SET   = 3'd3;
    localparam logic [2:0] IDX_CLR   = 3'd4;
    localparam logic [2:0] IDX_TGL   = 3'd5;
    localparam logic [2:0] IDX_IEN   = 3'd6;
    localparam logic [2:0] IDX_ISTAT = 3'd7;

    logic                                r_ready;
    logic [31:0]                         r_rdata;
    logic [WIDTH-1:0]                    r_out;
    logic [WIDTH-1:0]                    r_dir;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]   r_sync;

    logic             w_access;
    logic             w_wr;
    logic [2:0]       w_idx;
    logic [31:0]      w_mask32;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_bits;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_out_next;
    logic [WIDTH-1:0] w_dir_next;
    logic [31:0]      w_rdata_next;
    logic             w_unused;

    // The access is blocked while mem_ready is high, so the acknowledge
    // can never be asserted on two cycles in a row.
    assign w_access = mem_valid && CS && !r_ready;
    assign w_wr     = w_access && (mem_wstrb != 4'b0000);
    assign w_idx    = mem_addr[4:2];
    assign w_mask32 = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                       {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
    assign w_mask   = w_mask32[WIDTH-1:0];
    // Strobe-qualified data: unstrobed bytes contribute no set/clear/toggle bits.
    assign w_bits   = mem_wdata[WIDTH-1:0] & w_mask;
    assign w_in     = r_sync[SYNC_STAGES-1];
    assign w_unused = ^{mem_addr[31:5], mem_addr[1:0], mem_wdata};

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign gpio_o    = r_out;
    assign gpio_oe   = r_dir;

    always_comb begin
        w_out_next = r_out;
        w_dir_next = r_dir;
        if (w_wr) begin
            case (w_idx)
                IDX_OUT: w_out_next = (r_out & ~w_mask) | w_bits;
                IDX_DIR: w_dir_next = (r_dir & ~w_mask) | w_bits;
                IDX_SET: w_out_next = r_out | w_bits;
                IDX_CLR: w_out_next = r_out & ~w_bits;
                IDX_TGL: w_out_next = r_out ^ w_bits;
                default: ;
            endcase
        end
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] r_ien;
    logic [WIDTH-1:0] r_istat;
    logic [WIDTH-1:0] r_hist;
    logic             r_irq;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_ien_next;

    // Edges on disabled pins are dropped rather than latched.
    assign w_edge     = w_in & ~r_hist & r_ien;
    assign w_w1c      = (w_wr && (w_idx == IDX_ISTAT)) ? w_bits : '0;
    assign w_ien_next = (w_wr && (w_idx == IDX_IEN)) ? ((r_ien & ~w_mask) | w_bits) : r_ien;
    assign irq        = r_irq;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ien   <= '0;
            r_istat <= '0;
            r_hist  <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_ien   <= w_ien_next;
            // OR-ing the new edge in after the clear means a set on the same
            // cycle as a clear wins.
            r_istat <= (r_istat & ~w_w1c) | w_edge;
            r_hist  <= w_in;
            r_irq   <= |(r_istat & r_ien);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rdata_next = 32'd0;
        case (w_idx)
            IDX_OUT:   w_rdata_next = 32'(r_out);
            IDX_DIR:   w_rdata_next = 32'(r_dir);
            IDX_IN:    w_rdata_next = 32'(w_in);
`ifdef GPIO_IRQ_EN
            IDX_IEN:   w_rdata_next = 32'(r_ien);
            IDX_ISTAT: w_rdata_next = 32'(r_istat);
`endif
            default:   w_rdata_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
            r_out   <= '0;
            r_dir   <= '0;
        end else begin
            r_ready <= w_access;
            if (w_access) begin
                r_rdata <= w_rdata_next;
            end
            r_out <= w_out_next;
            r_dir <= w_dir_next;
        end
    end

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised general-purpose I/O peripheral on the PicoRV32-style native memory bus, successor to the fixed 32-bit output-only GPIO register. Provides WIDTH pins with per-pin direction, atomic set/clear/toggle writes, synchronised input sampling and rising-edge interrupts with write-1-to-clear status. Sits beside the RAM and UART slaves behind the system address decoder, which drives CS.

## Interface
- WIDTH, 32: number of GPIO pins, 1..32; register bits [31:WIDTH] read 0 and ignore writes.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- clk  in  1  system clock; all state on posedge.
- resetn  in  1  asynchronous, active-low reset.
- mem_valid  in  1  bus request valid.
- mem_ready  out  1  one-cycle acknowledge pulse.
- mem_addr  in  32  byte address; only [4:2] decoded.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes; 0 = read.
- mem_rdata  out  32  registered read data.
- CS  in  1  chip select from address decoder.
- gpio_i  in  WIDTH  asynchronous pin inputs.
- gpio_o  out  WIDTH  output data register.
- gpio_oe  out  WIDTH  output enable (1 = drive pin).
- irq  out  1  registered level interrupt.

## Operation
- Register map, word index mem_addr[4:2]:
  - 0 OUT: rw output data; drives gpio_o.
  - 1 DIR: rw; drives gpio_oe.
  - 2 IN: ro; synchronised gpio_i.
  - 3 SET: wo; OUT |= wdata (strobed bytes). Reads 0.
  - 4 CLR: wo; OUT &= ~wdata. Reads 0.
  - 5 TGL: wo; OUT ^= wdata. Reads 0.
  - 6 IEN: rw interrupt enable per pin.
  - 7 ISTAT: rw1c; writing 1 clears the bit, 0 leaves it unchanged.
- Byte strobes apply to every writable register; unstrobed bytes are unchanged and contribute no set/clear/toggle bits.
- Writes to IN are ignored but are still acknowledged.
- Input path: gpio_i passes through a SYNC_STAGES flip-flop chain, then one history register holding the previous synchronised value.
- Edge detect: a pin whose synchronised value is 1 and whose history is 0 sets ISTAT[n] when IEN[n]=1. Edges on disabled pins are discarded, not latched.
- irq is registered: irq <= |(ISTAT & IEN).

## Timing
- Reset (async assert): OUT, DIR, IEN, ISTAT, synchroniser and history registers, mem_ready, mem_rdata and irq all go to 0.
- Access: an access starts on the first edge where mem_valid && CS && !mem_ready.
  - On that edge, mem_ready becomes 1 for exactly one cycle.
  - mem_rdata is loaded on the same edge.
  - The register write commits on the same edge.
- Read data is the pre-write value of the addressed register.
- Back-to-back accesses run at one access per 2 cycles; mem_ready is never high on two consecutive cycles.
- gpio_o and gpio_oe change on the edge that sets mem_ready.
- Pin-to-IN latency: SYNC_STAGES cycles.
- Pin edge to ISTAT set: SYNC_STAGES+1 cycles. ISTAT to irq: +1 cycle.
- ISTAT write-1-to-clear on the same cycle as a new edge on that pin: set wins, so the bit stays 1.
- Clearing IEN[n] deasserts irq one cycle later; ISTAT[n] is retained.
- Reset asserted mid-access: mem_ready drops immediately and the write is lost. The master must re-issue the access after reset.

## Configuration
- GPIO_IRQ_EN defined: IEN, ISTAT, edge detector and irq are implemented as described.
- GPIO_IRQ_EN undefined:
  - IEN, ISTAT and the history register are removed.
  - Indices 6 and 7 read 0, ignore writes, and are still acknowledged.
  - irq is tied to 0.
  - IN, synchroniser and all other registers are unchanged.

## Test plan
- Reset with WIDTH=8, then read all 8 registers: mem_ready pulses 1 cycle per access, every read returns 0x00000000, gpio_o=0x00, gpio_oe=0x00.
- Write OUT=0xFFFFFFA5 with wstrb=0xF, then read it back: reads 0x000000A5, gpio_o=0xA5.
  - Then SET 0x0A → 0xAF; CLR 0x05 → 0xAA; TGL 0xFF → 0x55.
  - Each read of SET/CLR/TGL returns 0.
- With OUT=0x12345678 (WIDTH=32), write 0xAABBCCDD with wstrb=0x2: OUT=0x1234CC78. The same write's read data returns 0x12345678.
- IEN=0x01, then drive gpio_i[0] 0→1: ISTAT[0]=1 after 3 cycles and irq=1 one cycle later.
  - Drive gpio_i[1] 0→1 with IEN[1]=0: ISTAT[1] stays 0.
  - Write ISTAT=0x1: irq drops the following cycle.
- Align a W1C of ISTAT[0] with a fresh rising edge's set cycle: ISTAT[0] remains 1 and irq stays high.
- Build without GPIO_IRQ_EN, toggle gpio_i, write 0xFF to indices 6 and 7: irq stays 0, indices 6/7 read 0, IN tracks gpio_i after 2 cycles.
